// File: rtl/pc_redirect_sequencer.sv
// Fetch PC owner: sequential +4, branch/jump redirects with flush and bubbles, stall and halt.
// Latency: a redirect in cycle N shows its target on pc with pc_valid in cycle N+1+FLUSH_CYCLES; a stall holds pc.
// PCSEQ_DELAY_SLOT_EN: jumps keep one delay slot, with no flush and no bubble.
module pc_redirect_sequencer #(
    parameter int unsigned     PC_W         = 32,
    parameter logic [PC_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned     FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_ready,
    input  logic            stall,
    input  logic            halt_req,
    input  logic            jump_req,
    input  logic [25:0]     jump_index,
    input  logic [PC_W-1:0] jump_base,
    input  logic            branch_req,
    input  logic [15:0]     branch_offset,
    input  logic [PC_W-1:0] branch_base,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            flush,
    output logic [1:0]      state,
    output logic            halted
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_STALL  = 2'd1,
        S_BUBBLE = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [2:0]      cnt_q, cnt_d;

    logic [PC_W-1:0] jump_tgt;
    logic [PC_W-1:0] branch_tgt;
    logic [PC_W-1:0] redirect_pc;
    logic            redirect;
    logic            unused_jump_base;

    assign jump_tgt   = {jump_base[PC_W-1:28], jump_index, 2'b00};
    assign branch_tgt = branch_base + {{(PC_W-18){branch_offset[15]}}, branch_offset, 2'b00};
    assign unused_jump_base = ^jump_base[27:0];

`ifdef PCSEQ_DELAY_SLOT_EN
    logic            pend_vld_q, pend_vld_d;
    logic [PC_W-1:0] pend_pc_q, pend_pc_d;
    logic            jump_arm;

    // Only branches flush; a jump waits in the pending register for the slot to be fetched.
    assign redirect    = branch_req && (state_q != S_HALT);
    assign redirect_pc = branch_tgt;
    assign jump_arm    = jump_req && !branch_req && (state_q != S_HALT);
`else
    assign redirect    = (branch_req || jump_req) && (state_q != S_HALT);
    assign redirect_pc = branch_req ? branch_tgt : jump_tgt;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        pc_valid = (state_q == S_RUN);
        halted   = (state_q == S_HALT);
        flush    = 1'b0;
`ifdef PCSEQ_DELAY_SLOT_EN
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
`endif
        if (redirect) begin
            flush   = 1'b1;
            pc_d    = redirect_pc;
            state_d = S_BUBBLE;
            cnt_d   = 3'(FLUSH_CYCLES);
`ifdef PCSEQ_DELAY_SLOT_EN
            pend_vld_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (stall) begin
                        state_d = S_STALL;
                    end else if (fetch_ready) begin
`ifdef PCSEQ_DELAY_SLOT_EN
                        pc_d       = pend_vld_q ? pend_pc_q : pc_q + PC_W'(4);
                        pend_vld_d = 1'b0;
`else
                        pc_d = pc_q + PC_W'(4);
`endif
                    end
                end
                S_STALL: begin
                    if (halt_req) begin
                        state_d = S_HALT;
                    end else if (!stall) begin
                        state_d = S_RUN;
                    end
                end
                S_BUBBLE: begin
                    if (cnt_q <= 3'd1) begin
                        state_d = S_RUN;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase
`ifdef PCSEQ_DELAY_SLOT_EN
            if (jump_arm) begin
                pend_vld_d = 1'b1;
                pend_pc_d  = jump_tgt;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 3'd0;
`ifdef PCSEQ_DELAY_SLOT_EN
            pend_vld_q <= 1'b0;
            pend_pc_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
`ifdef PCSEQ_DELAY_SLOT_EN
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
`endif
        end
    end

    assign pc    = pc_q;
    assign state = state_q;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Directed bench for pc_redirect_sequencer (FLUSH_CYCLES=1, RESET_PC=0); inputs change and outputs are sampled at negedge.
module tb_pc_redirect_sequencer;

    logic        clk;
    logic        rst;
    logic        fetch_ready;
    logic        stall;
    logic        halt_req;
    logic        jump_req;
    logic [25:0] jump_index;
    logic [31:0] jump_base;
    logic        branch_req;
    logic [15:0] branch_offset;
    logic [31:0] branch_base;
    logic [31:0] pc;
    logic        pc_valid;
    logic        flush;
    logic [1:0]  state;
    logic        halted;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    pc_redirect_sequencer #(
        .PC_W(32), .RESET_PC(32'h0000_0000), .FLUSH_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst), .fetch_ready(fetch_ready), .stall(stall),
        .halt_req(halt_req), .jump_req(jump_req), .jump_index(jump_index),
        .jump_base(jump_base), .branch_req(branch_req), .branch_offset(branch_offset),
        .branch_base(branch_base), .pc(pc), .pc_valid(pc_valid), .flush(flush),
        .state(state), .halted(halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; fetch_ready = 1'b1; stall = 1'b0; halt_req = 1'b0;
        jump_req = 1'b0; jump_index = '0; jump_base = '0;
        branch_req = 1'b0; branch_offset = '0; branch_base = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(pc_valid), 32'd1);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        @(negedge clk); #1; chk("seq_4", pc, 32'h4);
        @(negedge clk); #1; chk("seq_8", pc, 32'h8);
        @(negedge clk); #1; chk("seq_12", pc, 32'hC);

        // Reach 0x1000_0040 through a branch: 0x1000_0000 + (0x10 << 2).
        @(negedge clk);
        branch_req = 1'b1; branch_base = 32'h1000_0000; branch_offset = 16'h0010; #1;
        chk("br1_flush", 32'(flush), 32'd1);
        @(negedge clk);
        branch_req = 1'b0; #1;
        chk("br1_pc", pc, 32'h1000_0040);
        chk("br1_bubble_valid", 32'(pc_valid), 32'd0);
        chk("br1_bubble_state", 32'(state), 32'd2);
        @(negedge clk); #1;
        chk("br1_run_valid", 32'(pc_valid), 32'd1);
        chk("br1_run_pc", pc, 32'h1000_0040);

`ifndef PCSEQ_DELAY_SLOT_EN
        jump_req = 1'b1; jump_index = 26'h0000123; jump_base = 32'h1000_0044; #1;
        chk("jmp_flush", 32'(flush), 32'd1);
        @(negedge clk);
        jump_req = 1'b0; #1;
        chk("jmp_pc", pc, 32'h1000_048C);
        chk("jmp_bubble_valid", 32'(pc_valid), 32'd0);
        @(negedge clk); #1;
        chk("jmp_run_valid", 32'(pc_valid), 32'd1);
        chk("jmp_run_pc", pc, 32'h1000_048C);
`endif

        // Branch and jump together: branch is older and wins.
        @(negedge clk);
        branch_req = 1'b1; branch_offset = 16'hFFFE; branch_base = 32'h0000_0100;
        jump_req = 1'b1; jump_index = 26'h0000123; jump_base = 32'h1000_0044; #1;
        chk("bvj_flush", 32'(flush), 32'd1);
        @(negedge clk);
        branch_req = 1'b0; jump_req = 1'b0; #1;
        chk("bvj_pc", pc, 32'h0000_00F8);
        chk("bvj_bubble_valid", 32'(pc_valid), 32'd0);

        // Stall for three cycles with a branch landing in the second.
        @(negedge clk);
        stall = 1'b1; #1;
        chk("stl_enter_valid", 32'(pc_valid), 32'd1);
        chk("stl_enter_pc", pc, 32'h0000_00F8);
        @(negedge clk); #1;
        chk("stl1_state", 32'(state), 32'd1);
        chk("stl1_valid", 32'(pc_valid), 32'd0);
        chk("stl1_pc", pc, 32'h0000_00F8);
        @(negedge clk);
        branch_req = 1'b1; branch_offset = 16'h0010; branch_base = 32'h0000_0200; #1;
        chk("stl2_flush", 32'(flush), 32'd1);
        chk("stl2_pc", pc, 32'h0000_00F8);
        @(negedge clk);
        branch_req = 1'b0; #1;
        chk("stl3_state", 32'(state), 32'd2);
        chk("stl3_pc", pc, 32'h0000_0240);
        chk("stl3_valid", 32'(pc_valid), 32'd0);
        @(negedge clk);
        stall = 1'b0; #1;
        chk("stl_run_state", 32'(state), 32'd0);
        chk("stl_run_valid", 32'(pc_valid), 32'd1);
        chk("stl_run_pc", pc, 32'h0000_0240);
        @(negedge clk); #1;
        chk("stl_adv_pc", pc, 32'h0000_0244);

        // Wrap: 0 + (-1 << 2) = 0xFFFF_FFFC, then +4 wraps to 0.
        @(negedge clk);
        branch_req = 1'b1; branch_offset = 16'hFFFF; branch_base = 32'h0; #1;
        @(negedge clk);
        branch_req = 1'b0;
        @(negedge clk); #1;
        chk("wrap_top_pc", pc, 32'hFFFF_FFFC);
        chk("wrap_top_valid", 32'(pc_valid), 32'd1);
        @(negedge clk); #1;
        chk("wrap_pc", pc, 32'h0);
        @(negedge clk);
        halt_req = 1'b1; #1;
        chk("halt_req_pc", pc, 32'h4);
        @(negedge clk);
        halt_req = 1'b0; jump_req = 1'b1; jump_index = 26'h0000123; jump_base = 32'h0; #1;
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_valid", 32'(pc_valid), 32'd0);
        chk("halt_jmp_flush", 32'(flush), 32'd0);
        chk("halt_state", 32'(state), 32'd3);
        @(negedge clk);
        jump_req = 1'b0; #1;
        chk("halt_frozen_pc", pc, 32'h4);
        chk("halt_stays", 32'(state), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; #1;
        chk("halt_rst_pc", pc, 32'h0);
        chk("halt_rst_state", 32'(state), 32'd0);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_valid", 32'(pc_valid), 32'd1);

`ifdef PCSEQ_DELAY_SLOT_EN
        branch_req = 1'b1; branch_offset = 16'h0010; branch_base = 32'h0; #1;
        @(negedge clk);
        branch_req = 1'b0;
        @(negedge clk); #1;
        chk("ds_start_pc", pc, 32'h40);
        jump_req = 1'b1; jump_index = 26'h0000200; jump_base = 32'h0; #1;
        chk("ds_no_flush", 32'(flush), 32'd0);
        @(negedge clk);
        jump_req = 1'b0; #1;
        chk("ds_slot_pc", pc, 32'h44);
        chk("ds_slot_valid", 32'(pc_valid), 32'd1);
        @(negedge clk); #1;
        chk("ds_target_pc", pc, 32'h800);
        chk("ds_target_valid", 32'(pc_valid), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
